emulador_hcsr04: RTL and testbench

Synthesizable responder for the HC-SR04 ultrasonic sensor protocol. It accepts the `trigger` pulse driven by the sonar measurement system and answers with an `echo` pulse whose width encodes a programmed distance in centimetres. It replaces hand-written echo stimulus in system benches, and serves as an on-board sensor stand-in for hardware-in-the-loop runs of the sonar/servo design.

---
 rtl/emulador_hcsr04.sv | 145 ++++++++++++++
 tb/tb_emulador_hcsr04.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/emulador_hcsr04.sv
// HC-SR04 ultrasonic sensor responder.
// Answers a valid trigger pulse with an echo whose width encodes distance.
module emulador_hcsr04 #(
  parameter int TRIG_MIN      = 500,
  parameter int ATRASO        = 20000,
  parameter int CICLOS_POR_CM = 2941,
  parameter int DIST_MAX      = 400,
  parameter int TIMEOUT       = 1900000,
  parameter int RECUPERA      = 50000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilitar,
  input  logic       trigger,
  input  logic [8:0] distancia,
  output logic       echo,
  output logic       ocupado,
  output logic       trigger_curto,
  output logic [7:0] medidas
);

  localparam int CW = 21;

  typedef enum logic [2:0] {
    ST_ESPERA,
    ST_MEDE_TRIG,
    ST_ATRASO,
    ST_ECO,
    ST_RECUPERA
  } estado_t;

  estado_t         state_q, state_d;
  logic            trigger_d_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   largura_q, largura_d;
  logic            echo_q, echo_d;
  logic            ocupado_q, ocupado_d;
  logic            curto_q, curto_d;
  logic [7:0]      medidas_q, medidas_d;

  logic            subida;
  logic            fora;
  logic [CW-1:0]   produto;
  logic [CW-1:0]   largura_calc;

  assign subida       = trigger & ~trigger_d_q;
  assign produto      = CW'(distancia) * CW'(CICLOS_POR_CM);
  assign fora         = (distancia == 9'd0) ||
                        (32'(distancia) > DIST_MAX);
  assign largura_calc = fora ? CW'(TIMEOUT) : produto;

  // Next-state, counters and registered outputs of the responder FSM
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    largura_d = largura_q;
    echo_d    = echo_q;
    curto_d   = 1'b0;
    medidas_d = medidas_q;
    unique case (state_q)
      ST_ESPERA: begin
        if (habilitar && subida) begin
          state_d = ST_MEDE_TRIG;
          cnt_d   = CW'(1);
        end
      end
      ST_MEDE_TRIG: begin
        if (trigger) begin
          if (cnt_q < CW'(TRIG_MIN))
            cnt_d = cnt_q + CW'(1);
        end else if (cnt_q >= CW'(TRIG_MIN)) begin
          state_d   = ST_ATRASO;
          cnt_d     = '0;
          largura_d = largura_calc;
        end else begin
          state_d = ST_ESPERA;
          cnt_d   = '0;
          curto_d = 1'b1;
        end
      end
      ST_ATRASO: begin
        if (cnt_q == CW'(ATRASO - 1)) begin
          state_d   = ST_ECO;
          cnt_d     = '0;
          echo_d    = 1'b1;
          medidas_d = medidas_q + 8'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_ECO: begin
        if (cnt_q == largura_q - CW'(1)) begin
          state_d = ST_RECUPERA;
          cnt_d   = '0;
          echo_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_RECUPERA: begin
        if (cnt_q == CW'(RECUPERA - 1)) begin
          state_d = ST_ESPERA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_ESPERA;
        cnt_d   = '0;
        echo_d  = 1'b0;
      end
    endcase
    ocupado_d = (state_d != ST_ESPERA);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_ESPERA;
      trigger_d_q <= 1'b0;
      cnt_q       <= '0;
      largura_q   <= '0;
      echo_q      <= 1'b0;
      ocupado_q   <= 1'b0;
      curto_q     <= 1'b0;
      medidas_q   <= '0;
    end else begin
      state_q     <= state_d;
      trigger_d_q <= trigger;
      cnt_q       <= cnt_d;
      largura_q   <= largura_d;
      echo_q      <= echo_d;
      ocupado_q   <= ocupado_d;
      curto_q     <= curto_d;
      medidas_q   <= medidas_d;
    end
  end

  assign echo          = echo_q;
  assign ocupado       = ocupado_q;
  assign trigger_curto = curto_q;
  assign medidas       = medidas_q;

endmodule

// File: tb/tb_emulador_hcsr04.sv
// Directed bench for emulador_hcsr04 with scaled-down timing.
// Expected echo widths are queued at stimulus time and popped on echo.
module tb_emulador_hcsr04;

  localparam int TMIN = 5;
  localparam int ATR  = 20;
  localparam int CPC  = 3;
  localparam int DMAX = 40;
  localparam int TOUT = 200;
  localparam int REC  = 30;

  logic       clock = 1'b0;
  logic       reset;
  logic       habilitar;
  logic       trigger;
  logic [8:0] distancia;
  logic       echo;
  logic       ocupado;
  logic       trigger_curto;
  logic [7:0] medidas;

  int checks = 0;
  int errors = 0;
  int sb[$];

  emulador_hcsr04 #(
    .TRIG_MIN     (TMIN),
    .ATRASO       (ATR),
    .CICLOS_POR_CM(CPC),
    .DIST_MAX     (DMAX),
    .TIMEOUT      (TOUT),
    .RECUPERA     (REC)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .habilitar    (habilitar),
    .trigger      (trigger),
    .distancia    (distancia),
    .echo         (echo),
    .ocupado      (ocupado),
    .trigger_curto(trigger_curto),
    .medidas      (medidas)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_w(input int d);
    if (d == 0 || d > DMAX) return TOUT;
    return d * CPC;
  endfunction

  task automatic pulse(input int n);
    trigger = 1'b1;
    repeat (n) tick();
    trigger = 1'b0;
  endtask

  // Measures delay from trigger fall, echo width and recovery time.
  task automatic measure(input string tag);
    int d, w, r, ew;
    d = 0;
    tick();
    while (echo !== 1'b1 && d < 2000) begin
      d++;
      tick();
    end
    w = 0;
    while (echo === 1'b1 && w < 5000) begin
      tick();
      w++;
    end
    r = 0;
    while (ocupado === 1'b1 && r < 5000) begin
      tick();
      r++;
    end
    ew = (sb.size() > 0) ? sb.pop_front() : -1;
    chk({tag, "_delay"}, d, ATR);
    chk({tag, "_width"}, w, ew);
    chk({tag, "_recov"}, r, REC);
  endtask

  task automatic run(input string tag, input int d);
    distancia = 9'(d);
    sb.push_back(model_w(d));
    pulse(TMIN);
    measure(tag);
  endtask

  initial begin
    int seen, w, ew, n;
    reset     = 1'b1;
    habilitar = 1'b1;
    trigger   = 1'b0;
    distancia = 9'd10;

    for (int i = 0; i < 4; i++) begin
      trigger = ~trigger;
      @(negedge clock);
    end
    tick();
    reset   = 1'b0;
    trigger = 1'b0;
    chk("rst_echo", int'(echo), 0);
    chk("rst_ocupado", int'(ocupado), 0);
    chk("rst_curto", int'(trigger_curto), 0);
    chk("rst_medidas", int'(medidas), 0);
    repeat (3) tick();

    distancia = 9'd10;
    sb.push_back(model_w(10));
    trigger = 1'b1;
    tick();
    chk("basic_ocup_rise", int'(ocupado), 1);
    repeat (TMIN - 1) tick();
    trigger = 1'b0;
    measure("basic");
    chk("basic_medidas", int'(medidas), 1);

    run("b2b_a", 7);
    run("b2b_b", 8);
    chk("b2b_medidas", int'(medidas), 3);

    distancia = 9'd10;
    pulse(TMIN - 1);
    tick();
    chk("short_curto_hi", int'(trigger_curto), 1);
    chk("short_ocupado", int'(ocupado), 0);
    tick();
    chk("short_curto_lo", int'(trigger_curto), 0);
    seen = 0;
    repeat (ATR + 10) begin
      tick();
      if (echo === 1'b1) seen = 1;
    end
    chk("short_no_echo", seen, 0);
    chk("short_medidas", int'(medidas), 3);

    run("dist0", 0);
    run("dist41", 41);
    run("dist40", 40);
    run("dist1", 1);
    run("dist511", 511);
    chk("bound_medidas", int'(medidas), 8);

    distancia = 9'd20;
    sb.push_back(model_w(20));
    pulse(TMIN);
    n = 0;
    while (echo !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    w = 0;
    distancia = 9'd10;
    trigger = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (echo === 1'b1) w++;
      tick();
    end
    trigger = 1'b0;
    while (echo === 1'b1 && w < 5000) begin
      tick();
      w++;
    end
    ew = (sb.size() > 0) ? sb.pop_front() : -1;
    chk("eco_disturb_width", w, ew);
    n = 0;
    while (ocupado === 1'b1 && n < 5000) begin
      tick();
      n++;
    end
    chk("eco_disturb_idle", int'(ocupado), 0);

    habilitar = 1'b0;
    distancia = 9'd10;
    pulse(TMIN);
    seen = 0;
    repeat (ATR + 40) begin
      tick();
      if (ocupado === 1'b1 || echo === 1'b1) seen = 1;
    end
    chk("hab0_no_resp", seen, 0);
    habilitar = 1'b1;
    repeat (2) tick();

    distancia = 9'd10;
    trigger = 1'b1;
    seen = 0;
    repeat (ATR * 3) begin
      tick();
      if (echo === 1'b1) seen = 1;
    end
    chk("held_no_echo", seen, 0);
    chk("held_ocupado", int'(ocupado), 1);
    sb.push_back(model_w(10));
    trigger = 1'b0;
    measure("held");
    chk("held_medidas", int'(medidas), 10);

    distancia = 9'd20;
    pulse(TMIN);
    n = 0;
    while (echo !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
    chk("mid_eco_echo_hi", int'(echo), 1);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_echo", int'(echo), 0);
    chk("mid_rst_medidas", int'(medidas), 0);
    chk("mid_rst_ocupado", int'(ocupado), 0);
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
